// File: rtl/fep_hdr_strip.sv
// FEP header stripper: validates the 12-byte header, votes the triplicated length,
// realigns the payload so output byte 0 is frame byte 12, and regenerates tlast/tkeep.
module fep_hdr_strip #(
   parameter int          DATA_WIDTH = 512,
   parameter logic [47:0] FEP_HEADER = 48'h1eadfeb5ac0d,
   parameter int          MIN_LEN    = 60,
   parameter int          MAX_LEN    = 1514
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
   input  logic                      s_axis_tvalid,
   output logic                      s_axis_tready,
   input  logic                      s_axis_tlast,
   output logic [DATA_WIDTH-1:0]     m_axis_tdata,
   output logic [DATA_WIDTH/8-1:0]   m_axis_tkeep,
   output logic                      m_axis_tvalid,
   input  logic                      m_axis_tready,
   output logic                      m_axis_tlast,
   output logic [31:0]               pkt_out_cnt,
   output logic [31:0]               hdr_err_cnt,
   output logic [31:0]               len_err_cnt,
   output logic [31:0]               tmr_fix_cnt
);
   // Realignment is hard-wired for a 64-byte beat: 12 header bytes + 52 held bytes.
   localparam int          KW     = DATA_WIDTH / 8;
   localparam int          HOLD_W = DATA_WIDTH - 96;
   localparam logic [15:0] MIN_L  = 16'(MIN_LEN);
   localparam logic [15:0] MAX_L  = 16'(MAX_LEN);

   typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH, S_DROP} state_t;

   state_t              state_q, state_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [10:0]         beats_left_q, beats_left_d;
   logic [6:0]          last_cnt_q, last_cnt_d;
   logic                drop_after_q, drop_after_d;

   logic [DATA_WIDTH-1:0] m_tdata_q;
   logic [KW-1:0]         m_tkeep_q;
   logic                  m_tvalid_q, m_tlast_q;
   logic [31:0]           pkt_cnt_q, hdr_cnt_q, len_cnt_q, tmr_cnt_q;

   logic                  out_load, out_last;
   logic [DATA_WIDTH-1:0] out_data;
   logic [KW-1:0]         out_keep;
   logic                  hdr_err_inc, len_err_inc, tmr_fix_inc;

   logic [15:0] len0, len1, len2, len_vote;
   logic [47:0] tag;
   logic [10:0] nin;
   logic [5:0]  rm1;
   logic [6:0]  r_val, hdr_last_cnt;
   logic        hdr_bad, accept, out_free;

   function automatic logic [KW-1:0] keep_mask(input logic [6:0] cnt);
      return ~({KW{1'b1}} << cnt);
   endfunction

   assign len0     = s_axis_tdata[15:0];
   assign len1     = s_axis_tdata[31:16];
   assign len2     = s_axis_tdata[47:32];
   assign tag      = s_axis_tdata[95:48];
   assign len_vote = (len0 & len1) | (len0 & len2) | (len1 & len2);

   // Nin = ceil(L/64); r = ((L-1) mod 64) + 1.
   assign nin     = {1'b0, len_vote[15:6]} + {10'd0, |len_vote[5:0]};
   assign rm1     = len_vote[5:0] - 6'd1;
   assign r_val   = {1'b0, rm1} + 7'd1;
   // Bytes in the final output beat: 52+r when the tail fits in the stream beat, else r-12.
   assign hdr_last_cnt = (rm1 < 6'd12) ? (7'd52 + r_val) : (r_val - 7'd12);
   assign hdr_bad = (tag != FEP_HEADER) || (len_vote < MIN_L) || (len_vote > MAX_L);

   assign out_free      = !m_tvalid_q || m_axis_tready;
   assign s_axis_tready = (state_q == S_DROP) || (out_free && (state_q != S_FLUSH));
   assign accept        = s_axis_tvalid && s_axis_tready;

   always_comb begin
      state_d      = state_q;
      hold_d       = hold_q;
      beats_left_d = beats_left_q;
      last_cnt_d   = last_cnt_q;
      drop_after_d = drop_after_q;
      out_load     = 1'b0;
      out_data     = '0;
      out_keep     = '0;
      out_last     = 1'b0;
      hdr_err_inc  = 1'b0;
      len_err_inc  = 1'b0;
      tmr_fix_inc  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (hdr_bad) begin
                  hdr_err_inc = 1'b1;
                  state_d     = s_axis_tlast ? S_IDLE : S_DROP;
               end else begin
                  tmr_fix_inc  = !((len0 == len1) && (len1 == len2));
                  hold_d       = s_axis_tdata[DATA_WIDTH-1:96];
                  beats_left_d = nin - 11'd1;
                  last_cnt_d   = hdr_last_cnt;
                  drop_after_d = 1'b0;
                  if (nin == 11'd1) begin
                     state_d = S_FLUSH;
                     if (!s_axis_tlast) begin
                        len_err_inc  = 1'b1;
                        drop_after_d = 1'b1;
                     end
                  end else if (s_axis_tlast) begin
                     len_err_inc = 1'b1;
                     last_cnt_d  = 7'd52;
                     state_d     = S_FLUSH;
                  end else begin
                     state_d = S_STREAM;
                  end
               end
            end
         end
         S_STREAM: begin
            if (accept) begin
               out_load     = 1'b1;
               hold_d       = s_axis_tdata[DATA_WIDTH-1:96];
               beats_left_d = beats_left_q - 11'd1;
               if (beats_left_q == 11'd1) begin
                  out_data = {s_axis_tdata[95:0], hold_q};
                  if (!s_axis_tlast) begin
                     len_err_inc  = 1'b1;
                     drop_after_d = 1'b1;
                  end
                  if (last_cnt_q > 7'd52) begin
                     out_keep = keep_mask(last_cnt_q);
                     out_last = 1'b1;
                     state_d  = s_axis_tlast ? S_IDLE : S_DROP;
                  end else begin
                     out_keep = '1;
                     state_d  = S_FLUSH;
                  end
               end else if (s_axis_tlast) begin
                  // Truncated packet: close out with what is held, drop this beat.
                  len_err_inc = 1'b1;
                  out_data    = {96'd0, hold_q};
                  out_keep    = keep_mask(7'd52);
                  out_last    = 1'b1;
                  state_d     = S_IDLE;
               end else begin
                  out_data = {s_axis_tdata[95:0], hold_q};
                  out_keep = '1;
               end
            end
         end
         S_FLUSH: begin
            if (out_free) begin
               out_load = 1'b1;
               out_data = {96'd0, hold_q};
               out_keep = keep_mask(last_cnt_q);
               out_last = 1'b1;
               state_d  = drop_after_q ? S_DROP : S_IDLE;
            end
         end
         S_DROP: begin
            if (accept && s_axis_tlast) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         hold_q       <= '0;
         beats_left_q <= '0;
         last_cnt_q   <= '0;
         drop_after_q <= 1'b0;
         m_tdata_q    <= '0;
         m_tkeep_q    <= '0;
         m_tvalid_q   <= 1'b0;
         m_tlast_q    <= 1'b0;
         pkt_cnt_q    <= '0;
         hdr_cnt_q    <= '0;
         len_cnt_q    <= '0;
         tmr_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         beats_left_q <= beats_left_d;
         last_cnt_q   <= last_cnt_d;
         drop_after_q <= drop_after_d;
         if (out_load) begin
            m_tdata_q  <= out_data;
            m_tkeep_q  <= out_keep;
            m_tlast_q  <= out_last;
            m_tvalid_q <= 1'b1;
         end else if (m_axis_tready) begin
            m_tvalid_q <= 1'b0;
         end
         if (m_tvalid_q && m_axis_tready && m_tlast_q) pkt_cnt_q <= pkt_cnt_q + 32'd1;
         if (hdr_err_inc) hdr_cnt_q <= hdr_cnt_q + 32'd1;
         if (len_err_inc) len_cnt_q <= len_cnt_q + 32'd1;
         if (tmr_fix_inc) tmr_cnt_q <= tmr_cnt_q + 32'd1;
      end
   end

   assign m_axis_tdata  = m_tdata_q;
   assign m_axis_tkeep  = m_tkeep_q;
   assign m_axis_tvalid = m_tvalid_q;
   assign m_axis_tlast  = m_tlast_q;
   assign pkt_out_cnt   = pkt_cnt_q;
   assign hdr_err_cnt   = hdr_cnt_q;
   assign len_err_cnt   = len_cnt_q;
   assign tmr_fix_cnt   = tmr_cnt_q;

endmodule

// File: tb/tb_fep_hdr_strip.sv
// Scoreboard bench for fep_hdr_strip: expected beats are built from the frame bytes
// (frame minus 12 header bytes) and compared as the DUT emits them.
`timescale 1ns/1ps
module tb_fep_hdr_strip;
   localparam logic [47:0] TAG = 48'h1eadfeb5ac0d;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [511:0] s_axis_tdata = '0;
   logic         s_axis_tvalid = 1'b0;
   logic         s_axis_tready;
   logic         s_axis_tlast = 1'b0;
   logic [511:0] m_axis_tdata;
   logic [63:0]  m_axis_tkeep;
   logic         m_axis_tvalid;
   logic         m_axis_tready = 1'b1;
   logic         m_axis_tlast;
   logic [31:0]  pkt_out_cnt, hdr_err_cnt, len_err_cnt, tmr_fix_cnt;

   fep_hdr_strip dut (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tlast(m_axis_tlast),
      .pkt_out_cnt(pkt_out_cnt), .hdr_err_cnt(hdr_err_cnt),
      .len_err_cnt(len_err_cnt), .tmr_fix_cnt(tmr_fix_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [511:0] d;
      logic [63:0]  k;
      logic         l;
   } beat_t;

   beat_t      exp_q[$];
   logic [7:0] frame_b [4096];
   int         n_checks = 0;
   int         n_errors = 0;
   int         ready_mode = 0;   // 0: always ready, 1: random, 2: never ready
   bit         mon_en = 1'b1;
   int         pkt_no = 0;
   int         exp_pkt = 0, exp_hdr = 0, exp_len = 0, exp_tmr = 0;

   // Downstream ready generator
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            1:       m_axis_tready = 1'($urandom_range(0, 1));
            2:       m_axis_tready = 1'b0;
            default: m_axis_tready = 1'b1;
         endcase
      end
   end

   // Output monitor: pops the scoreboard on every handshake, checks hold-while-stalled.
   initial begin
      beat_t        e;
      logic [511:0] mask, prev_d;
      logic [63:0]  prev_k;
      logic         prev_l;
      bit           stalled = 1'b0;
      forever begin
         @(negedge clk);
         if (mon_en && !rst && m_axis_tvalid) begin
            if (stalled) begin
               n_checks++;
               if (m_axis_tdata !== prev_d || m_axis_tkeep !== prev_k || m_axis_tlast !== prev_l) begin
                  n_errors++;
                  $display("FAIL hold_stable: got keep=%h last=%b, required keep=%h last=%b (data held)",
                           m_axis_tkeep, m_axis_tlast, prev_k, prev_l);
               end
            end
            if (m_axis_tready) begin
               stalled = 1'b0;
               n_checks++;
               if (exp_q.size() == 0) begin
                  n_errors++;
                  $display("FAIL unexpected_beat: got keep=%h last=%b, required no output",
                           m_axis_tkeep, m_axis_tlast);
               end else begin
                  e = exp_q.pop_front();
                  for (int i = 0; i < 64; i++) mask[8*i +: 8] = {8{e.k[i]}};
                  if (m_axis_tkeep !== e.k || m_axis_tlast !== e.l || (m_axis_tdata & mask) !== e.d) begin
                     n_errors++;
                     $display("FAIL out_beat: got keep=%h last=%b data=%h, required keep=%h last=%b data=%h",
                              m_axis_tkeep, m_axis_tlast, m_axis_tdata & mask, e.k, e.l, e.d);
                  end
               end
            end else begin
               stalled = 1'b1;
               prev_d  = m_axis_tdata;
               prev_k  = m_axis_tkeep;
               prev_l  = m_axis_tlast;
            end
         end else begin
            stalled = 1'b0;
         end
      end
   end

   task automatic make_frame(input logic [15:0] l0, input logic [15:0] l1, input logic [15:0] l2,
                             input logic [47:0] tg, input int nbytes);
      for (int i = 0; i < nbytes; i++) frame_b[i] = 8'($urandom);
      frame_b[0] = l0[7:0];  frame_b[1] = l0[15:8];
      frame_b[2] = l1[7:0];  frame_b[3] = l1[15:8];
      frame_b[4] = l2[7:0];  frame_b[5] = l2[15:8];
      for (int i = 0; i < 6; i++) frame_b[6+i] = tg[8*i +: 8];
   endtask

   // Expected output: frame bytes [start, start+count) packed 64 per beat.
   task automatic push_bytes(input int start, input int count);
      int nb;
      nb = (count + 63) / 64;
      for (int k = 0; k < nb; k++) begin
         beat_t e;
         e.d = '0;
         e.k = '0;
         for (int i = 0; i < 64; i++) begin
            if (64*k + i < count) begin
               e.d[8*i +: 8] = frame_b[start + 64*k + i];
               e.k[i]        = 1'b1;
            end
         end
         e.l = (k == nb - 1);
         exp_q.push_back(e);
      end
   endtask

   task automatic send_beat(input logic [511:0] d, input logic last);
      int waitc;
      waitc = 0;
      s_axis_tdata  = d;
      s_axis_tlast  = last;
      s_axis_tvalid = 1'b1;
      while (1) begin
         @(negedge clk);
         if (s_axis_tready) break;
         waitc++;
         if (waitc > 2000) begin
            n_checks++;
            n_errors++;
            $display("FAIL input_accept: got tready=0 for %0d cycles, required 1", waitc);
            break;
         end
      end
      @(posedge clk);
      #1;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   task automatic send_frame(input int nbeats);
      logic [511:0] d;
      pkt_no++;
      $display("pkt %0d: len0=%0d beats=%0d", pkt_no, {frame_b[1], frame_b[0]}, nbeats);
      for (int j = 0; j < nbeats; j++) begin
         for (int i = 0; i < 64; i++) d[8*i +: 8] = frame_b[64*j + i];
         send_beat(d, j == nbeats - 1);
      end
   endtask

   task automatic wait_drain(output bit ok);
      ok = 1'b0;
      repeat (4) @(negedge clk);
      for (int c = 0; c < 20000; c++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !m_axis_tvalid) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tkeep !== 64'd0 || m_axis_tdata !== 512'd0) begin
         n_errors++;
         $display("FAIL reset_outputs: got valid=%b last=%b keep=%h, required all zero",
                  m_axis_tvalid, m_axis_tlast, m_axis_tkeep);
      end
      n_checks++;
      if (pkt_out_cnt !== 0 || hdr_err_cnt !== 0 || len_err_cnt !== 0 || tmr_fix_cnt !== 0) begin
         n_errors++;
         $display("FAIL reset_counters: got %0d/%0d/%0d/%0d, required 0/0/0/0",
                  pkt_out_cnt, hdr_err_cnt, len_err_cnt, tmr_fix_cnt);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
      n_checks++;
      if (s_axis_tready !== 1'b1) begin
         n_errors++;
         $display("FAIL reset_tready: got %b, required 1", s_axis_tready);
      end
   endtask

   // One valid packet of length L sent as nbeats input beats; the caller pushes expectations.
   task automatic test_packet(input string name, input int len, input int nbeats, input int out_bytes);
      bit ok;
      make_frame(16'(len), 16'(len), 16'(len), TAG, 64 * nbeats);
      push_bytes(12, out_bytes);
      send_frame(nbeats);
      exp_pkt++;
      wait_drain(ok);
      n_checks++;
      if (!ok || pkt_out_cnt !== 32'(exp_pkt)) begin
         n_errors++;
         $display("FAIL %s: got pkt_out_cnt=%0d drained=%0d, required %0d drained=1",
                  name, pkt_out_cnt, ok, exp_pkt);
      end
   endtask

   task automatic test_tmr_vote();
      bit ok;
      make_frame(16'd100, 16'd100, 16'hFFFF, TAG, 128);
      push_bytes(12, 88);
      send_frame(2);
      exp_pkt++;
      exp_tmr++;
      wait_drain(ok);
      n_checks++;
      if (!ok || tmr_fix_cnt !== 32'(exp_tmr) || pkt_out_cnt !== 32'(exp_pkt)) begin
         n_errors++;
         $display("FAIL tmr_vote: got tmr_fix_cnt=%0d pkt=%0d, required %0d pkt=%0d",
                  tmr_fix_cnt, pkt_out_cnt, exp_tmr, exp_pkt);
      end
   endtask

   task automatic test_bad_tag();
      bit ok;
      make_frame(16'd150, 16'd150, 16'd150, 48'h1eadfeb5ac0c, 192);
      send_frame(3);
      exp_hdr++;
      wait_drain(ok);
      n_checks++;
      if (!ok || hdr_err_cnt !== 32'(exp_hdr) || pkt_out_cnt !== 32'(exp_pkt)) begin
         n_errors++;
         $display("FAIL bad_tag: got hdr_err_cnt=%0d pkt=%0d, required %0d pkt=%0d",
                  hdr_err_cnt, pkt_out_cnt, exp_hdr, exp_pkt);
      end
      test_packet("after_bad_tag", 90, 2, 78);
   endtask

   task automatic test_early_tlast();
      bit ok;
      // L=200 expects 4 beats; tlast on the third leaves 64 + 52 bytes of output.
      make_frame(16'd200, 16'd200, 16'd200, TAG, 192);
      push_bytes(12, 116);
      send_frame(3);
      exp_pkt++;
      exp_len++;
      wait_drain(ok);
      n_checks++;
      if (!ok || len_err_cnt !== 32'(exp_len) || pkt_out_cnt !== 32'(exp_pkt)) begin
         n_errors++;
         $display("FAIL early_tlast: got len_err_cnt=%0d pkt=%0d, required %0d pkt=%0d",
                  len_err_cnt, pkt_out_cnt, exp_len, exp_pkt);
      end
   endtask

   task automatic test_late_tlast();
      bit ok;
      // L=76 expects 2 beats; a third beat is sent, the packet closes after 64 bytes.
      make_frame(16'd76, 16'd76, 16'd76, TAG, 192);
      push_bytes(12, 64);
      send_frame(3);
      exp_pkt++;
      exp_len++;
      wait_drain(ok);
      n_checks++;
      if (!ok || len_err_cnt !== 32'(exp_len) || pkt_out_cnt !== 32'(exp_pkt)) begin
         n_errors++;
         $display("FAIL late_tlast: got len_err_cnt=%0d pkt=%0d, required %0d pkt=%0d",
                  len_err_cnt, pkt_out_cnt, exp_len, exp_pkt);
      end
      test_packet("after_late_tlast", 128, 2, 116);
   endtask

   task automatic test_back_to_back();
      bit ok;
      int len, nin;
      ready_mode = 1;
      for (int p = 0; p < 100; p++) begin
         len = $urandom_range(60, 1514);
         nin = (len + 63) / 64;
         make_frame(16'(len), 16'(len), 16'(len), TAG, 64 * nin);
         push_bytes(12, len - 12);
         send_frame(nin);
         exp_pkt++;
      end
      wait_drain(ok);
      ready_mode = 0;
      n_checks++;
      if (!ok || pkt_out_cnt !== 32'(exp_pkt)) begin
         n_errors++;
         $display("FAIL back_to_back: got pkt_out_cnt=%0d drained=%0d, required %0d drained=1",
                  pkt_out_cnt, ok, exp_pkt);
      end
      n_checks++;
      if (hdr_err_cnt !== 32'(exp_hdr) || len_err_cnt !== 32'(exp_len) || tmr_fix_cnt !== 32'(exp_tmr)) begin
         n_errors++;
         $display("FAIL back_to_back_errs: got %0d/%0d/%0d, required %0d/%0d/%0d",
                  hdr_err_cnt, len_err_cnt, tmr_fix_cnt, exp_hdr, exp_len, exp_tmr);
      end
   endtask

   task automatic test_mid_reset();
      logic [511:0] d;
      mon_en = 1'b0;
      ready_mode = 2;
      make_frame(16'd300, 16'd300, 16'd300, TAG, 320);
      pkt_no++;
      $display("pkt %0d: len0=300 beats=2 (reset mid-packet)", pkt_no);
      for (int j = 0; j < 2; j++) begin
         for (int i = 0; i < 64; i++) d[8*i +: 8] = frame_b[64*j + i];
         send_beat(d, 1'b0);
      end
      n_checks++;
      if (m_axis_tvalid !== 1'b1) begin
         n_errors++;
         $display("FAIL mid_reset_pending: got valid=%b, required 1", m_axis_tvalid);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tkeep !== 64'd0 || m_axis_tdata !== 512'd0) begin
         n_errors++;
         $display("FAIL mid_reset_outputs: got valid=%b last=%b keep=%h, required all zero",
                  m_axis_tvalid, m_axis_tlast, m_axis_tkeep);
      end
      n_checks++;
      if (pkt_out_cnt !== 0 || len_err_cnt !== 0) begin
         n_errors++;
         $display("FAIL mid_reset_counters: got pkt=%0d len_err=%0d, required 0/0", pkt_out_cnt, len_err_cnt);
      end
      rst = 1'b0;
      exp_q.delete();
      exp_pkt = 0; exp_hdr = 0; exp_len = 0; exp_tmr = 0;
      ready_mode = 0;
      mon_en = 1'b1;
      @(posedge clk);
      #1;
      test_packet("after_mid_reset", 76, 2, 64);
   endtask

   initial begin
      test_reset();
      test_packet("single_beat_60", 60, 1, 48);
      test_packet("two_beat_76", 76, 2, 64);
      test_packet("two_beat_128", 128, 2, 116);
      test_tmr_vote();
      test_bad_tag();
      test_early_tlast();
      test_late_tlast();
      test_back_to_back();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #20ms;
      $display("FAIL global_timeout: got no completion, required finish");
      $fatal(1, "timeout");
   end

endmodule
